// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: walks one external full adder LSB-first over WIDTH
// cycles and returns {c_out, sum} = a + b + c_in with a fixed latency.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic              busy_q;
  logic              done_q;

  // Partial result with the current bit folded in, so the final edge can publish it whole.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = fa_sum;
  end

  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == StRun) begin
      fa_a   = a_q[idx_q];
      fa_b   = b_q[idx_q];
      fa_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx_q   <= '0;
            acc_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          carry_q <= fa_carry;
          idx_q   <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= acc_d;
            cout_q  <= fa_carry;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request one addition; sampled each rising edge.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- c_in  input  1  carry-in; sampled with an accepted start.
- fa_a  output  1  bit to the external 1-bit full adder input a.
- fa_b  output  1  bit to the external full adder input b.
- fa_cin  output  1  carry to the external full adder input c_in.
- fa_sum  input  1  sum returned by the external full adder (combinational).
- fa_carry  input  1  carry returned by the external full adder (combinational).
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result sum, registered.
- c_out  output  1  final carry-out, registered.

Function
REQ-004 The block SHALL sequence a single external 1-bit full adder LSB-first over WIDTH cycles to compute {c_out,sum} = a + b + c_in.
REQ-005 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-006 FSM transitions SHALL be:
- IDLE: start=1 -> RUN; otherwise stay in IDLE.
- RUN: bit index = WIDTH-1 -> DONE; otherwise stay in RUN.
- DONE: start=1 -> RUN; otherwise -> IDLE.
REQ-007 An accepted start (in IDLE or DONE) SHALL capture a, b and c_in into internal registers, clear the bit index to 0, and clear the result shift register.
REQ-008 In RUN, the fa_* outputs SHALL be driven as follows: fa_a = a_reg[idx], fa_b = b_reg[idx], fa_cin = carry_reg.
REQ-009 On each RUN edge, the block SHALL set sum_reg[idx] <= fa_sum, carry_reg <= fa_carry, and idx <= idx+1.
REQ-010 Outside RUN, fa_a, fa_b and fa_cin SHALL be 0.
REQ-011 busy SHALL be 1 exactly while in RUN.
REQ-012 done SHALL be 1 exactly while in DONE.
REQ-013 Latency SHALL be fixed: for start sampled at edge k, busy is high for cycles k+1..k+WIDTH and done is high in cycle k+WIDTH+1.
REQ-014 sum and c_out SHALL update only on the final RUN edge, then hold their value until the next final RUN edge or reset.
REQ-015 start while in RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-016 start asserted in the DONE cycle SHALL be accepted back-to-back, with no IDLE cycle.
REQ-017 The block SHALL accept any a/b values including all-ones; the carry out of bit WIDTH-1 SHALL go to c_out only.
REQ-018 The block SHALL implement no arithmetic of its own; all sum and carry bits SHALL come from fa_sum and fa_carry.

Reset
REQ-019 On rst=1 at a rising edge, the block SHALL enter IDLE and clear the following to 0: busy, done, sum, c_out, fa_a, fa_b, fa_cin, idx, carry_reg, a_reg and b_reg.
REQ-020 Reset SHALL take priority over start and over any in-progress RUN; an operation aborted by reset SHALL produce no done pulse.

Verification
REQ-021 With WIDTH=8, the bench SHALL connect a behavioural full adder to the fa_* ports and check the following scenarios:
- a=3, b=5, c_in=0, start pulse -> busy high for 8 cycles, then done high for 1 cycle with sum=8, c_out=0.
- a=255, b=1, c_in=0 -> sum=0, c_out=1.
- a=255, b=255, c_in=1 -> sum=255, c_out=1.
- start with a=10, b=20; start re-pulsed with a=0, b=0 during RUN -> second start ignored; result sum=30, done exactly once.
- start held high across DONE with new operands a=1, b=1 -> first result sum=a0+b0; next RUN begins with no IDLE gap; second done shows sum=2.
- rst=1 asserted in the 4th RUN cycle -> next cycle: IDLE, busy=0, sum=0, c_out=0; no done until a new start.
